data_mem_responder: RTL and testbench

- Word-addressed data-memory responder: the target end of the processor's load/store interface.
- Replaces the zero-latency combinational data memory with a registered request/response handshake and a programmable wait-state latency.
- Accepts one load or store at a time. Returns read data, or a write acknowledge, after LATENCY cycles.
- Sits between the processor datapath (or a future stall-capable pipeline) and the data-memory array it owns internally.

---
 rtl/data_mem_responder.sv | 99 +++++++++
 tb/tb_data_mem_responder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Word-addressed data-memory target with a registered request/response handshake.
// One access is in flight at a time; the response appears LATENCY cycles after acceptance.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // Counter start value; BUSY is always entered, so the access edge lands LATENCY edges after acceptance.
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t            state_reg, state_next;
  logic [3:0]        cnt_reg;
  logic              cap_we_reg;
  logic [31:0]       cap_addr_reg;
  logic [31:0]       cap_wdata_reg;
  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              access;
  logic              addr_err;
  logic [ADDR_W-1:0] idx;

  assign accept   = (state_reg == IDLE) && req_valid;
  assign access   = (state_reg == BUSY) && (cnt_reg == 4'd0);
  assign addr_err = |cap_addr_reg[31:ADDR_W];
  assign idx      = cap_addr_reg[ADDR_W-1:0];

  always_ff @(posedge CLK) begin
    if (RST) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (req_valid)         state_next = BUSY;
      BUSY:    if (cnt_reg == 4'd0)   state_next = RESP;
      RESP:    if (resp_ready)        state_next = IDLE;
      default:                        state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_reg == IDLE) && !RST;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_reg       <= 4'd0;
      cap_we_reg    <= 1'b0;
      cap_addr_reg  <= 32'd0;
      cap_wdata_reg <= 32'd0;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'd0;
      resp_err      <= 1'b0;
    end else begin
      if (accept) begin
        cap_we_reg    <= req_we;
        cap_addr_reg  <= req_addr;
        cap_wdata_reg <= req_wdata;
        cnt_reg       <= CNT_INIT;
      end else if (state_reg == BUSY && cnt_reg != 4'd0) begin
        cnt_reg <= cnt_reg - 4'd1;
      end

      if (access) begin
        resp_valid <= 1'b1;
        resp_err   <= addr_err;
        resp_rdata <= (!cap_we_reg && !addr_err) ? mem[idx] : 32'd0;
      end else if (state_reg == RESP && resp_ready) begin
        resp_valid <= 1'b0;
        resp_err   <= 1'b0;
        resp_rdata <= 32'd0;
      end
    end
  end

  // Array has no reset; a store whose access edge meets reset is dropped.
  always_ff @(posedge CLK) begin
    if (!RST && access && cap_we_reg && !addr_err)
      mem[idx] <= cap_wdata_reg;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder: unit 0 built with LATENCY=2, unit 1 with LATENCY=1,
// both checked against an array model of the memory and the handshake timing rules.
module tb_data_mem_responder;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [31:0] req_addr   [2];
  logic [31:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [31:0] resp_rdata [2];
  logic        resp_err   [2];

  logic [31:0] model [2][1024];
  int errors;
  int checks;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    data_mem_responder #(
      .DEPTH(1024), .ADDR_W(10), .LATENCY((gi == 0) ? 2 : 1)
    ) dut (
      .CLK(clk), .RST(rst[gi]),
      .req_valid(req_valid[gi]), .req_ready(req_ready[gi]), .req_we(req_we[gi]),
      .req_addr(req_addr[gi]), .req_wdata(req_wdata[gi]),
      .resp_valid(resp_valid[gi]), .resp_ready(resp_ready[gi]),
      .resp_rdata(resp_rdata[gi]), .resp_err(resp_err[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int lat_of(input int u);
    return (u == 0) ? 2 : 1;
  endfunction

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel <= 6)      return 32'($urandom_range(0, 15));
    else if (sel == 7) return 32'd1023;
    else if (sel == 8) return 32'd1024;
    else               return $urandom | 32'h0000_0400;
  endfunction

  // One full request/response exchange, with `hold` cycles of response backpressure.
  task automatic do_txn(input int u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold);
    int          w;
    int          lat;
    logic        err;
    logic [31:0] exp_rd;
    err    = (addr >= 32'd1024);
    exp_rd = (we || err) ? 32'd0 : model[u][addr[9:0]];
    w = 0;
    while (!req_ready[u] && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_wait", {31'b0, req_ready[u]}, 32'd1);
    req_we[u]    = we;
    req_addr[u]  = addr;
    req_wdata[u] = wdata;
    req_valid[u] = 1'b1;
    @(posedge clk); #1;
    req_valid[u] = 1'b0;
    req_we[u]    = 1'($urandom);
    req_addr[u]  = $urandom;
    req_wdata[u] = $urandom;
    lat = 0;
    while (!resp_valid[u] && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(lat_of(u)));
    check("rdata", resp_rdata[u], exp_rd);
    check("err", {31'b0, resp_err[u]}, {31'b0, err});
    if (we && !err) model[u][addr[9:0]] = wdata;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
    end
    if (hold > 0) begin
      check("hold_flags", {30'b0, resp_valid[u], req_ready[u]}, 32'd2);
      check("hold_rdata", resp_rdata[u], exp_rd);
    end
    resp_ready[u] = 1'b1;
    @(posedge clk); #1;
    resp_ready[u] = 1'b0;
    check("consume", {29'b0, resp_valid[u], req_ready[u], resp_err[u]}, 32'd2);
    check("consume_rdata", resp_rdata[u], 32'd0);
    $display("txn u=%0d we=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d hold=%0d",
             u, we, addr, wdata, exp_rd, err, hold);
  endtask

  initial begin
    int ready_cnt;
    int valid_cnt;
    errors = 0;
    checks = 0;
    for (int u = 0; u < 2; u++) begin
      rst[u]        = 1'b1;
      req_valid[u]  = 1'b1;
      req_we[u]     = 1'b0;
      req_addr[u]   = 32'd0;
      req_wdata[u]  = 32'd0;
      resp_ready[u] = 1'b0;
    end

    // Reset held two cycles with a request pending
    repeat (2) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      check("rst_ready", {31'b0, req_ready[u]}, 32'd0);
      check("rst_outs", {30'b0, resp_valid[u], resp_err[u]}, 32'd0);
      check("rst_rdata", resp_rdata[u], 32'd0);
      rst[u] = 1'b0;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      check("ready_after_rst", {31'b0, req_ready[u]}, 32'd1);
      req_valid[u] = 1'b0;
    end

    // Preload the addresses the random phase uses
    for (int u = 0; u < 2; u++) begin
      for (int a = 0; a < 16; a++) do_txn(u, 1'b1, 32'(a), $urandom, 0);
      do_txn(u, 1'b1, 32'd1023, $urandom, 0);
    end

    // Directed cases on the LATENCY=2 unit
    do_txn(0, 1'b1, 32'd5, 32'hDEAD_BEEF, 0);
    do_txn(0, 1'b0, 32'd5, 32'd0, 4);
    do_txn(0, 1'b1, 32'd1024, 32'h1234_5678, 0);
    do_txn(0, 1'b0, 32'd0, 32'd0, 0);
    do_txn(0, 1'b0, 32'hFFFF_FFFF, 32'd0, 1);

    // Reset lands on the access edge of a store: no response, array unchanged
    req_we[0]    = 1'b1;
    req_addr[0]  = 32'd7;
    req_wdata[0] = 32'hA5A5_A5A5;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", {31'b0, resp_valid[0]}, 32'd0);
    rst[0] = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_idle", {30'b0, resp_valid[0], req_ready[0]}, 32'd1);
    do_txn(0, 1'b0, 32'd7, 32'd0, 0);

    // LATENCY=1 back-to-back: one acceptance every 3 cycles
    resp_ready[1] = 1'b1;
    req_we[1]     = 1'b0;
    req_addr[1]   = 32'd3;
    req_valid[1]  = 1'b1;
    ready_cnt = 0;
    valid_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (req_ready[1]) ready_cnt++;
      if (resp_valid[1]) begin
        valid_cnt++;
        check("b2b_rdata", resp_rdata[1], model[1][3]);
      end
    end
    req_valid[1]  = 1'b0;
    resp_ready[1] = 1'b0;
    check("b2b_ready_cnt", 32'(ready_cnt), 32'd4);
    check("b2b_resp_cnt", 32'(valid_cnt), 32'd4);
    @(posedge clk); #1;

    // Randomized traffic on both builds
    for (int u = 0; u < 2; u++) begin
      for (int n = 0; n < 40; n++) begin
        do_txn(u, 1'($urandom_range(0, 1)), rand_addr(), $urandom, $urandom_range(0, 3));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
